// File: rtl/intc_pkg.sv
// Shared types and constants for the interrupt controller: FSM states,
// source indices and the source-to-exception-code mapping.
package intc_pkg;

  localparam int NUM_SRC = 7;
  localparam int SEL_W   = 3;

  localparam logic [3:0] EXC_RESET    = 4'd0;
  localparam logic [3:0] EXC_MMU      = 4'd2;
  localparam logic [3:0] EXC_TIMER0   = 4'd3;
  localparam logic [3:0] EXC_TIMER1   = 4'd4;
  localparam logic [3:0] EXC_TIMER2   = 4'd5;
  localparam logic [3:0] EXC_TIMER3   = 4'd6;
  localparam logic [3:0] EXC_UART0_RX = 4'd7;
  localparam logic [3:0] EXC_UART0_TX = 4'd8;

  localparam int SRC_MMU      = 0;
  localparam int SRC_UART0_TX = 1;
  localparam int SRC_UART0_RX = 2;
  localparam int SRC_TIMER0   = 3;
  localparam int SRC_TIMER1   = 4;
  localparam int SRC_TIMER2   = 5;
  localparam int SRC_TIMER3   = 6;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    INSERVICE
  } intc_state_e;

  // Indexed by source bit position (bit 0 = MMU ... bit 6 = TIMER3).
  localparam logic [3:0] SRC_CODE [0:NUM_SRC-1] = '{
    EXC_MMU, EXC_UART0_TX, EXC_UART0_RX,
    EXC_TIMER0, EXC_TIMER1, EXC_TIMER2, EXC_TIMER3
  };

  function automatic logic [3:0] exc_code(input logic [SEL_W-1:0] idx);
    if (int'(idx) < NUM_SRC) return SRC_CODE[idx];
    return EXC_RESET;
  endfunction

endpackage

// File: rtl/intc_prio_sel.sv
// Combinational priority select: reports whether any request is set and
// the index of the highest set bit.
module intc_prio_sel #(
  parameter int N = 7,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [W-1:0] idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    // Ascending scan so the highest set bit is the last one written.
    for (int i = 0; i < N; i++) begin
      if (req[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Captures peripheral interrupt edges, masks them and delivers the
// highest-priority one to the CPU through a req/ack/eoi handshake.
module interrupt_controller
  import intc_pkg::*;
#(
  parameter int NSRC = NUM_SRC
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [3:0]      timer_in,
  input  logic [1:0]      serial0_in,
  input  logic            mmu,
  input  logic            enabled,
  input  logic            cfg_we,
  input  logic [NSRC-1:0] cfg_mask,
  input  logic            cpu_ack,
  input  logic            cpu_eoi,
  output logic            cpu_irq,
  output logic [3:0]      cpu_exception,
  output logic [NSRC-1:0] pending,
  output logic [NSRC-1:0] mask,
  output logic            in_service
);

  logic [NSRC-1:0] src;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] eligible;
  logic [NSRC-1:0] clr;
  logic            win_valid;
  logic [SEL_W-1:0] win_idx;

  intc_state_e      state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             irq_q, irq_d;
  logic [3:0]       exc_q, exc_d;
  logic             insvc_q, insvc_d;
  logic [NSRC-1:0]  pending_q, pending_d;
  logic [NSRC-1:0]  mask_q, mask_d;
  logic [NSRC-1:0]  src_q, src_d;

  assign src      = {timer_in, serial0_in, mmu};
  assign rise     = src & ~src_q;
  assign eligible = pending_q & mask_q;

  intc_prio_sel #(
    .N(NSRC),
    .W(SEL_W)
  ) u_prio_sel (
    .req  (eligible),
    .valid(win_valid),
    .idx  (win_idx)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    irq_d   = irq_q;
    exc_d   = exc_q;
    insvc_d = insvc_q;
    src_d   = src;
    mask_d  = cfg_we ? cfg_mask : mask_q;
    clr     = '0;

    case (state_q)
      IDLE: begin
        if (enabled && win_valid) begin
          state_d = REQ;
          sel_d   = win_idx;
          irq_d   = 1'b1;
          exc_d   = exc_code(win_idx);
        end else begin
          irq_d = 1'b0;
          exc_d = EXC_RESET;
        end
      end
      REQ: begin
        // Ack takes precedence over a simultaneous drop of enabled.
        if (cpu_ack) begin
          state_d = INSERVICE;
          clr     = NSRC'(1) << sel_q;
          irq_d   = 1'b0;
          insvc_d = 1'b1;
        end else if (!enabled) begin
          state_d = IDLE;
          irq_d   = 1'b0;
          exc_d   = EXC_RESET;
        end
      end
      INSERVICE: begin
        if (cpu_eoi) begin
          state_d = IDLE;
          insvc_d = 1'b0;
          exc_d   = EXC_RESET;
        end
      end
      default: begin
        state_d = IDLE;
        irq_d   = 1'b0;
        exc_d   = EXC_RESET;
        insvc_d = 1'b0;
      end
    endcase

    // A fresh edge on the granted source survives its own ack.
    pending_d = (pending_q & ~clr) | rise;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      irq_q     <= 1'b0;
      exc_q     <= EXC_RESET;
      insvc_q   <= 1'b0;
      pending_q <= '0;
      mask_q    <= '0;
      src_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      irq_q     <= irq_d;
      exc_q     <= exc_d;
      insvc_q   <= insvc_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      src_q     <= src_d;
    end
  end

  assign cpu_irq       = irq_q;
  assign cpu_exception = exc_q;
  assign pending       = pending_q;
  assign mask          = mask_q;
  assign in_service    = insvc_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: scenario tasks check state
// inline, a monitor pops the expected exception code on every new request.
module tb_interrupt_controller;
  import intc_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [3:0] timer_in;
  logic [1:0] serial0_in;
  logic       mmu;
  logic       enabled;
  logic       cfg_we;
  logic [6:0] cfg_mask;
  logic       cpu_ack;
  logic       cpu_eoi;
  logic       cpu_irq;
  logic [3:0] cpu_exception;
  logic [6:0] pending;
  logic [6:0] mask;
  logic       in_service;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];
  logic       irq_prev = 1'b0;
  int         req_num = 0;

  interrupt_controller dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .timer_in     (timer_in),
    .serial0_in   (serial0_in),
    .mmu          (mmu),
    .enabled      (enabled),
    .cfg_we       (cfg_we),
    .cfg_mask     (cfg_mask),
    .cpu_ack      (cpu_ack),
    .cpu_eoi      (cpu_eoi),
    .cpu_irq      (cpu_irq),
    .cpu_exception(cpu_exception),
    .pending      (pending),
    .mask         (mask),
    .in_service   (in_service)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "watchdog");
  end

  // Scoreboard consumer: each new rising of cpu_irq is one request transaction.
  always @(posedge clk_i) begin
    logic [3:0] exp;
    #1;
    if (cpu_irq === 1'b1 && irq_prev !== 1'b1) begin
      req_num++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_req: code=%0d, required no request", cpu_exception);
      end else begin
        exp = exp_q.pop_front();
        $display("req %0d: code=%0d expected=%0d", req_num, cpu_exception, exp);
        if (cpu_exception !== exp) begin
          errors++;
          $display("FAIL sb_req_code: code=%0d, required %0d", cpu_exception, exp);
        end
      end
    end
    irq_prev = cpu_irq;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic ack_eoi();
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    cpu_eoi = 1'b1;
    tick();
    cpu_eoi = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    timer_in = '0; serial0_in = '0; mmu = 1'b0; enabled = 1'b0;
    cfg_we = 1'b0; cfg_mask = '0; cpu_ack = 1'b0; cpu_eoi = 1'b0;
    tick();
    tick();
    checks += 5;
    if (cpu_irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b, required 0", cpu_irq); end
    if (cpu_exception !== EXC_RESET) begin errors++; $display("FAIL reset_exc: got %0d, required %0d", cpu_exception, EXC_RESET); end
    if (pending !== 7'h00) begin errors++; $display("FAIL reset_pending: got %h, required 00", pending); end
    if (mask !== 7'h00) begin errors++; $display("FAIL reset_mask: got %h, required 00", mask); end
    if (in_service !== 1'b0) begin errors++; $display("FAIL reset_insvc: got %b, required 0", in_service); end
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    cfg_mask = 7'h7F; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    checks++;
    if (mask !== 7'h7F) begin errors++; $display("FAIL basic_mask: got %h, required 7f", mask); end
    enabled = 1'b1;
    exp_q.push_back(EXC_TIMER0);
    timer_in = 4'b0001;
    tick();
    timer_in = 4'b0000;
    checks += 2;
    if (pending !== 7'h08) begin errors++; $display("FAIL basic_pending: got %h, required 08", pending); end
    if (cpu_irq !== 1'b0) begin errors++; $display("FAIL basic_irq_early: got %b, required 0", cpu_irq); end
    tick();
    checks++;
    if (cpu_irq !== 1'b1) begin errors++; $display("FAIL basic_irq: got %b, required 1", cpu_irq); end
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    checks += 4;
    if (pending !== 7'h00) begin errors++; $display("FAIL basic_ack_pending: got %h, required 00", pending); end
    if (in_service !== 1'b1) begin errors++; $display("FAIL basic_insvc: got %b, required 1", in_service); end
    if (cpu_irq !== 1'b0) begin errors++; $display("FAIL basic_ack_irq: got %b, required 0", cpu_irq); end
    if (cpu_exception !== EXC_TIMER0) begin errors++; $display("FAIL basic_hold_exc: got %0d, required %0d", cpu_exception, EXC_TIMER0); end
    cpu_eoi = 1'b1;
    tick();
    cpu_eoi = 1'b0;
    checks += 2;
    if (in_service !== 1'b0) begin errors++; $display("FAIL basic_eoi_insvc: got %b, required 0", in_service); end
    if (cpu_exception !== EXC_RESET) begin errors++; $display("FAIL basic_eoi_exc: got %0d, required %0d", cpu_exception, EXC_RESET); end
  endtask

  task automatic test_simultaneous();
    exp_q.push_back(EXC_TIMER3);
    exp_q.push_back(EXC_MMU);
    timer_in = 4'b1000; mmu = 1'b1;
    tick();
    timer_in = 4'b0000; mmu = 1'b0;
    checks++;
    if (pending !== 7'h41) begin errors++; $display("FAIL simul_pending: got %h, required 41", pending); end
    tick();
    checks++;
    if (cpu_irq !== 1'b1 || cpu_exception !== EXC_TIMER3) begin errors++; $display("FAIL simul_first: irq=%b code=%0d, required 1/%0d", cpu_irq, cpu_exception, EXC_TIMER3); end
    ack_eoi();
    checks++;
    if (pending !== 7'h01 || cpu_irq !== 1'b0) begin errors++; $display("FAIL simul_after_eoi: pending=%h irq=%b, required 01/0", pending, cpu_irq); end
    tick();
    checks++;
    if (cpu_irq !== 1'b1 || cpu_exception !== EXC_MMU) begin errors++; $display("FAIL simul_second: irq=%b code=%0d, required 1/%0d", cpu_irq, cpu_exception, EXC_MMU); end
    ack_eoi();
    checks++;
    if (pending !== 7'h00) begin errors++; $display("FAIL simul_drain: pending=%h, required 00", pending); end
  endtask

  task automatic test_mask();
    cfg_mask = 7'h00; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    serial0_in = 2'b10;
    tick();
    serial0_in = 2'b00;
    checks++;
    if (pending !== 7'h04) begin errors++; $display("FAIL mask_pending: got %h, required 04", pending); end
    tick();
    tick();
    checks++;
    if (cpu_irq !== 1'b0 || pending !== 7'h04) begin errors++; $display("FAIL mask_held: irq=%b pending=%h, required 0/04", cpu_irq, pending); end
    exp_q.push_back(EXC_UART0_RX);
    cfg_mask = 7'h04; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    checks++;
    if (cpu_irq !== 1'b0) begin errors++; $display("FAIL mask_irq_early: got %b, required 0", cpu_irq); end
    tick();
    checks++;
    if (cpu_irq !== 1'b1 || cpu_exception !== EXC_UART0_RX) begin errors++; $display("FAIL mask_unmask_req: irq=%b code=%0d, required 1/%0d", cpu_irq, cpu_exception, EXC_UART0_RX); end
    ack_eoi();
    cfg_mask = 7'h7F; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic test_withdraw();
    exp_q.push_back(EXC_TIMER1);
    exp_q.push_back(EXC_TIMER1);
    timer_in = 4'b0010;
    tick();
    timer_in = 4'b0000;
    tick();
    checks++;
    if (cpu_irq !== 1'b1 || cpu_exception !== EXC_TIMER1) begin errors++; $display("FAIL wd_req: irq=%b code=%0d, required 1/%0d", cpu_irq, cpu_exception, EXC_TIMER1); end
    enabled = 1'b0;
    tick();
    checks++;
    if (cpu_irq !== 1'b0 || cpu_exception !== EXC_RESET || pending !== 7'h10) begin
      errors++;
      $display("FAIL wd_withdraw: irq=%b code=%0d pending=%h, required 0/%0d/10", cpu_irq, cpu_exception, pending, EXC_RESET);
    end
    tick();
    checks++;
    if (cpu_irq !== 1'b0) begin errors++; $display("FAIL wd_stay_idle: irq=%b, required 0", cpu_irq); end
    enabled = 1'b1;
    tick();
    checks++;
    if (cpu_irq !== 1'b1 || cpu_exception !== EXC_TIMER1) begin errors++; $display("FAIL wd_represent: irq=%b code=%0d, required 1/%0d", cpu_irq, cpu_exception, EXC_TIMER1); end
    ack_eoi();
  endtask

  task automatic test_in_service();
    exp_q.push_back(EXC_TIMER0);
    timer_in = 4'b0001;
    tick();
    timer_in = 4'b0000;
    tick();
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    exp_q.push_back(EXC_TIMER2);
    timer_in = 4'b0100;
    tick();
    timer_in = 4'b0000;
    checks++;
    if (pending !== 7'h20 || cpu_irq !== 1'b0) begin errors++; $display("FAIL isvc_accum: pending=%h irq=%b, required 20/0", pending, cpu_irq); end
    tick();
    tick();
    checks++;
    if (cpu_irq !== 1'b0 || in_service !== 1'b1) begin errors++; $display("FAIL isvc_no_nest: irq=%b insvc=%b, required 0/1", cpu_irq, in_service); end
    cpu_eoi = 1'b1;
    tick();
    cpu_eoi = 1'b0;
    checks++;
    if (cpu_irq !== 1'b0 || in_service !== 1'b0) begin errors++; $display("FAIL isvc_eoi: irq=%b insvc=%b, required 0/0", cpu_irq, in_service); end
    tick();
    checks++;
    if (cpu_irq !== 1'b1 || cpu_exception !== EXC_TIMER2) begin errors++; $display("FAIL isvc_next: irq=%b code=%0d, required 1/%0d", cpu_irq, cpu_exception, EXC_TIMER2); end
    ack_eoi();

    exp_q.push_back(EXC_TIMER0);
    timer_in = 4'b0001;
    tick();
    timer_in = 4'b0000;
    tick();
    cpu_ack = 1'b1; timer_in = 4'b0001;
    tick();
    cpu_ack = 1'b0; timer_in = 4'b0000;
    checks++;
    if (pending !== 7'h08 || in_service !== 1'b1) begin errors++; $display("FAIL coll_pending: pending=%h insvc=%b, required 08/1", pending, in_service); end
    exp_q.push_back(EXC_TIMER0);
    cpu_eoi = 1'b1;
    tick();
    cpu_eoi = 1'b0;
    tick();
    checks++;
    if (cpu_irq !== 1'b1 || cpu_exception !== EXC_TIMER0) begin errors++; $display("FAIL coll_rereq: irq=%b code=%0d, required 1/%0d", cpu_irq, cpu_exception, EXC_TIMER0); end
    ack_eoi();
    checks++;
    if (pending !== 7'h00) begin errors++; $display("FAIL coll_drain: pending=%h, required 00", pending); end
  endtask

  task automatic test_async_reset();
    exp_q.push_back(EXC_TIMER3);
    timer_in = 4'b1000;
    tick();
    timer_in = 4'b0000;
    tick();
    checks++;
    if (cpu_irq !== 1'b1) begin errors++; $display("FAIL arst_pre_req: irq=%b, required 1", cpu_irq); end
    #2;
    rst_i = 1'b1;
    #1;
    checks += 4;
    if (cpu_irq !== 1'b0) begin errors++; $display("FAIL arst_irq: got %b, required 0", cpu_irq); end
    if (pending !== 7'h00) begin errors++; $display("FAIL arst_pending: got %h, required 00", pending); end
    if (mask !== 7'h00) begin errors++; $display("FAIL arst_mask: got %h, required 00", mask); end
    if (cpu_exception !== EXC_RESET) begin errors++; $display("FAIL arst_exc: got %0d, required %0d", cpu_exception, EXC_RESET); end
    tick();
    rst_i = 1'b0;
    tick();
    tick();
    checks++;
    if (cpu_irq !== 1'b0 || in_service !== 1'b0) begin errors++; $display("FAIL arst_after: irq=%b insvc=%b, required 0/0", cpu_irq, in_service); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_simultaneous();
    test_mask();
    test_withdraw();
    test_in_service();
    test_async_reset();
    tick();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover: %0d expected requests not seen, required 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
